// File: rtl/tx_arbiter.sv
// tx_arbiter: shares the network_stack transmit input between NUM_REQ sources, one buffered frame per grant.
// Define TX_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration; the default build is round-robin.
module tx_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_SIZE  = 16,
   parameter int MAX_WORDS  = 8,
   parameter int GAP_CYCLES = 1024,
   localparam int GW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
   input  logic [NUM_REQ-1:0]             req_last,
   input  logic [NUM_REQ*16-1:0]          req_port,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           axiov,
   output logic [DATA_SIZE-1:0]           axiod,
   output logic [15:0]                    udp_dst_port_out,
   output logic [GW-1:0]                  grant_id,
   output logic                           busy
);
   // state   | meaning
   // IDLE    | waiting for any req_valid, arbitrates on it
   // COLLECT | accepting words from grant_id into frame_buf
   // SEND    | replaying frame_buf[0..count-1] on axiov/axiod
   // GAP     | axiov low for GAP_CYCLES so the stack drains
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SEND, S_GAP} state_t;

   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam int AW = (MAX_WORDS > 2) ? $clog2(MAX_WORDS) : 1;
   localparam int TW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

   state_t                 state, state_nxt;
   logic [CW-1:0]          count, rd_idx;
   logic [TW-1:0]          gap_cnt;
   logic [DATA_SIZE-1:0]   frame_buf [MAX_WORDS];
   logic [GW-1:0]          win_id;
   logic [15:0]            win_port;
   logic [DATA_SIZE-1:0]   sel_data;
   logic                   sel_valid, sel_last;
   logic                   hs, frame_end;

`ifdef TX_ARB_FIXED_PRIORITY_EN
   always_comb begin
      win_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req_valid[i]) win_id = GW'(i);
   end
`else
   logic [GW-1:0] last_grant;
   logic [GW-1:0] rr_idx;
   logic          win_found;

   always_comb begin
      win_id    = '0;
      rr_idx    = '0;
      win_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_idx = GW'((int'(last_grant) + k) % NUM_REQ);
         if (!win_found && req_valid[rr_idx]) begin
            win_found = 1'b1;
            win_id    = rr_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= GW'(NUM_REQ - 1);
      else if (state == S_IDLE && |req_valid)
         last_grant <= win_id;
   end
`endif

   // Constant-base muxes keep the variable grant index out of part-select arithmetic.
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      win_port  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == GW'(i)) begin
            sel_data  = req_data[i*DATA_SIZE +: DATA_SIZE];
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
         end
         if (win_id == GW'(i)) win_port = req_port[i*16 +: 16];
      end
   end

   assign hs        = (state == S_COLLECT) && sel_valid && (count < CW'(MAX_WORDS));
   assign frame_end = hs && (sel_last || (count == CW'(MAX_WORDS - 1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (|req_valid) state_nxt = S_COLLECT;
         S_COLLECT: if (frame_end) state_nxt = S_SEND;
         S_SEND:    if (rd_idx == count - CW'(1)) state_nxt = S_GAP;
         S_GAP:     if (gap_cnt == '0) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count            <= '0;
         rd_idx           <= '0;
         gap_cnt          <= '0;
         grant_id         <= '0;
         udp_dst_port_out <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|req_valid) begin
                  grant_id         <= win_id;
                  udp_dst_port_out <= win_port;
                  count            <= '0;
               end
            end
            S_COLLECT: begin
               rd_idx <= '0;
               if (hs) count <= count + CW'(1);
            end
            S_SEND: begin
               rd_idx <= rd_idx + CW'(1);
               if (state_nxt == S_GAP) gap_cnt <= TW'(GAP_CYCLES - 1);
            end
            S_GAP: begin
               if (gap_cnt != '0) gap_cnt <= gap_cnt - TW'(1);
            end
            default: ;
         endcase
      end
   end

   // Buffer contents are don't-care after reset; count gates every read.
   always_ff @(posedge clk) begin
      if (hs) frame_buf[count[AW-1:0]] <= sel_data;
   end

   assign busy  = (state != S_IDLE);
   assign axiov = (state == S_SEND);
   assign axiod = axiov ? frame_buf[rd_idx[AW-1:0]] : '0;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++)
         req_ready[i] = (state == S_COLLECT) && (grant_id == GW'(i)) && (count < CW'(MAX_WORDS));
   end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed bench for tx_arbiter with a short gap and a negedge burst monitor.
module tb_tx_arbiter;
   localparam int NR = 2;
   localparam int DW = 16;
   localparam int MW = 8;
   localparam int G  = 16;

   logic                eth_refclk = 1'b0;
   logic                rst_n = 1'b0;
   logic [NR-1:0]       req_valid = '0;
   logic [NR-1:0]       req_last = '0;
   logic [NR*DW-1:0]    req_data = '0;
   logic [NR*16-1:0]    req_port = '0;
   logic [NR-1:0]       req_ready;
   logic                axiov;
   logic [DW-1:0]       axiod;
   logic [15:0]         udp_dst_port_out;
   logic [0:0]          grant_id;
   logic                busy;

   int tests = 0;
   int failed = 0;
   int cyc = 0;

   tx_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .MAX_WORDS(MW), .GAP_CYCLES(G)) dut (
      .clk(eth_refclk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_port(req_port),
      .req_ready(req_ready), .axiov(axiov), .axiod(axiod), .udp_dst_port_out(udp_dst_port_out),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 eth_refclk = ~eth_refclk;
   always @(posedge eth_refclk) cyc <= cyc + 1;

   // burst monitor
   logic [15:0] words_q[$];
   int          len_q[$];
   int          rise_q[$];
   int          gnt_q[$];
   logic [15:0] port_q[$];
   int          cur_len = 0;
   logic        prev_v = 1'b0;
   int          rdy_bad = 0;

   always @(negedge eth_refclk) begin
      if (axiov && !prev_v) begin
         rise_q.push_back(cyc);
         gnt_q.push_back(int'(grant_id));
         port_q.push_back(udp_dst_port_out);
      end
      if (axiov) words_q.push_back(axiod);
      if (!axiov && prev_v) len_q.push_back(cur_len);
      cur_len <= axiov ? (prev_v ? cur_len + 1 : 1) : 0;
      prev_v  <= axiov;
      if (axiov && |req_ready) rdy_bad <= rdy_bad + 1;
   end

   logic [15:0] fw [0:15];
   int          acc [0:15];
   int          start_cyc;
   int          idle_cyc;

   task automatic clr_mon();
      words_q.delete(); len_q.delete(); rise_q.delete(); gnt_q.delete(); port_q.delete();
      rdy_bad = 0;
   endtask

   task automatic send_frame(input int r, input int n, input int stall_after, input int stall_len);
      @(negedge eth_refclk);
      start_cyc = cyc;
      for (int i = 0; i < n; i++) begin
         int t;
         req_valid[r] = 1'b1;
         req_data[r*DW +: DW] = fw[i];
         req_last[r] = (i == n - 1);
         t = 0;
         while (!req_ready[r] && t < 400) begin
            @(negedge eth_refclk);
            t++;
         end
         if (!req_ready[r]) begin
            tests++; failed++;
            $display("FAIL handshake_timeout req%0d word%0d: req_ready=0, required 1", r, i);
         end
         acc[i] = cyc;
         @(negedge eth_refclk);
         if (i == stall_after) begin
            req_valid[r] = 1'b0;
            req_last[r] = 1'b0;
            repeat (stall_len) @(negedge eth_refclk);
         end
      end
      req_valid[r] = 1'b0;
      req_last[r] = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 2000) begin
         @(negedge eth_refclk);
         t++;
      end
      idle_cyc = cyc;
      if (busy) begin
         tests++; failed++;
         $display("FAIL idle_timeout: busy=1, required 0");
      end
      repeat (2) @(negedge eth_refclk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge eth_refclk);
      tests++; if (axiov !== 1'b0) begin failed++; $display("FAIL rst_axiov: got %b want 0", axiov); end
      tests++; if (axiod !== 16'h0) begin failed++; $display("FAIL rst_axiod: got %h want 0", axiod); end
      tests++; if (req_ready !== 2'b00) begin failed++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
      tests++; if (udp_dst_port_out !== 16'h0) begin failed++; $display("FAIL rst_port: got %0d want 0", udp_dst_port_out); end
      tests++; if (grant_id !== 1'b0) begin failed++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      @(negedge eth_refclk);
   endtask

   task automatic test_single();
      clr_mon();
      fw[0] = 16'hABCD; fw[1] = 16'h6969;
      req_port[15:0] = 16'd42069;
      send_frame(0, 2, -1, 0);
      wait_idle();
      tests++; if (acc[0] !== start_cyc + 1) begin failed++; $display("FAIL single_ready_latency: got %0d want %0d", acc[0], start_cyc + 1); end
      tests++; if (len_q.size() !== 1 || len_q[0] !== 2) begin failed++; $display("FAIL single_len: got %0d bursts len %0d want 1 len 2", len_q.size(), len_q[0]); end
      tests++; if (words_q[0] !== 16'hABCD) begin failed++; $display("FAIL single_w0: got %h want abcd", words_q[0]); end
      tests++; if (words_q[1] !== 16'h6969) begin failed++; $display("FAIL single_w1: got %h want 6969", words_q[1]); end
      tests++; if (port_q[0] !== 16'd42069) begin failed++; $display("FAIL single_port: got %0d want 42069", port_q[0]); end
      tests++; if (gnt_q[0] !== 0) begin failed++; $display("FAIL single_grant: got %0d want 0", gnt_q[0]); end
      tests++; if (rise_q[0] !== acc[1] + 1) begin failed++; $display("FAIL single_first_axiov: got %0d want %0d", rise_q[0], acc[1] + 1); end
      tests++; if (idle_cyc !== acc[1] + 2 + G + 1) begin failed++; $display("FAIL single_busy_fall: got %0d want %0d", idle_cyc, acc[1] + 2 + G + 1); end
   endtask

   task automatic test_overlength();
      clr_mon();
      for (int i = 0; i < 10; i++) fw[i] = 16'h2000 + 16'(i);
      req_port[31:16] = 16'h1234;
      send_frame(1, 10, -1, 0);
      wait_idle();
      tests++; if (len_q.size() !== 2 || len_q[0] !== 8 || len_q[1] !== 2) begin failed++; $display("FAIL over_lens: got n=%0d %0d,%0d want 2 bursts 8,2", len_q.size(), len_q[0], len_q[1]); end
      for (int i = 0; i < 10; i++) begin
         tests++; if (words_q[i] !== fw[i]) begin failed++; $display("FAIL over_word%0d: got %h want %h", i, words_q[i], fw[i]); end
      end
      tests++; if (acc[8] - acc[7] !== G + 10) begin failed++; $display("FAIL over_rearb_gap: got %0d want %0d", acc[8] - acc[7], G + 10); end
      tests++; if (rise_q[1] - rise_q[0] !== G + 11) begin failed++; $display("FAIL over_rise_gap: got %0d want %0d", rise_q[1] - rise_q[0], G + 11); end
      tests++; if (rdy_bad !== 0) begin failed++; $display("FAIL over_ready_in_send: got %0d cycles want 0", rdy_bad); end
      tests++; if (gnt_q[0] !== 1 || gnt_q[1] !== 1) begin failed++; $display("FAIL over_grant: got %0d,%0d want 1,1", gnt_q[0], gnt_q[1]); end
      tests++; if (port_q[1] !== 16'h1234) begin failed++; $display("FAIL over_port: got %h want 1234", port_q[1]); end
   endtask

   task automatic test_simultaneous();
      int exp_g [4];
      int t = 0;
`ifdef TX_ARB_FIXED_PRIORITY_EN
      exp_g = '{0, 0, 0, 0};
`else
      exp_g = '{0, 1, 0, 1};
`endif
      clr_mon();
      @(negedge eth_refclk);
      req_data = {16'h5A01, 16'h5A00};
      req_last = 2'b11;
      req_valid = 2'b11;
      while (rise_q.size() < 4 && t < 4 * (G + 3) + 40) begin
         @(negedge eth_refclk);
         t++;
      end
      req_valid = 2'b00;
      req_last = 2'b00;
      wait_idle();
      tests++; if (rise_q.size() < 4) begin failed++; $display("FAIL sim_burst_count: got %0d want >=4", rise_q.size()); end
      for (int k = 0; k < 4; k++) begin
         tests++; if (gnt_q[k] !== exp_g[k]) begin failed++; $display("FAIL sim_grant%0d: got %0d want %0d", k, gnt_q[k], exp_g[k]); end
         tests++; if (words_q[k] !== 16'h5A00 + 16'(exp_g[k])) begin failed++; $display("FAIL sim_word%0d: got %h want %h", k, words_q[k], 16'h5A00 + 16'(exp_g[k])); end
      end
   endtask

   task automatic test_stall();
      clr_mon();
      for (int i = 0; i < 4; i++) fw[i] = 16'h3000 + 16'(i);
      send_frame(0, 4, 1, 20);
      wait_idle();
      tests++; if (acc[2] - acc[1] !== 21) begin failed++; $display("FAIL stall_resume: got %0d want 21", acc[2] - acc[1]); end
      tests++; if (rise_q.size() !== 1) begin failed++; $display("FAIL stall_bursts: got %0d want 1", rise_q.size()); end
      tests++; if (rise_q[0] !== acc[3] + 1) begin failed++; $display("FAIL stall_first_axiov: got %0d want %0d", rise_q[0], acc[3] + 1); end
      tests++; if (len_q[0] !== 4) begin failed++; $display("FAIL stall_len: got %0d want 4", len_q[0]); end
      tests++; if (words_q[3] !== 16'h3003) begin failed++; $display("FAIL stall_w3: got %h want 3003", words_q[3]); end
   endtask

   task automatic test_gap();
      int t = 0;
      clr_mon();
      @(negedge eth_refclk);
      req_data[15:0] = 16'h6000;
      req_last[0] = 1'b1;
      req_valid[0] = 1'b1;
      while (rise_q.size() < 3 && t < 3 * (G + 3) + 40) begin
         @(negedge eth_refclk);
         t++;
      end
      req_valid[0] = 1'b0;
      req_last[0] = 1'b0;
      wait_idle();
      tests++; if (rise_q[1] - rise_q[0] !== 1 + G + 2) begin failed++; $display("FAIL gap_period01: got %0d want %0d", rise_q[1] - rise_q[0], 1 + G + 2); end
      tests++; if (rise_q[2] - rise_q[1] !== 1 + G + 2) begin failed++; $display("FAIL gap_period12: got %0d want %0d", rise_q[2] - rise_q[1], 1 + G + 2); end
      tests++; if (len_q[0] !== 1) begin failed++; $display("FAIL gap_pulse_len: got %0d want 1", len_q[0]); end
   endtask

   task automatic test_reset_mid();
      int t = 0;
      clr_mon();
      for (int i = 0; i < 5; i++) fw[i] = 16'h7001 + 16'(i);
      req_port[15:0] = 16'd7;
      send_frame(0, 5, -1, 0);
      while (!axiov && t < 50) begin
         @(negedge eth_refclk);
         t++;
      end
      repeat (2) @(negedge eth_refclk);
      tests++; if (axiod !== 16'h7003) begin failed++; $display("FAIL rmid_word3: got %h want 7003", axiod); end
      #1 rst_n = 1'b0;
      #1;
      tests++; if (axiov !== 1'b0) begin failed++; $display("FAIL rmid_axiov: got %b want 0", axiov); end
      tests++; if (req_ready !== 2'b00) begin failed++; $display("FAIL rmid_ready: got %b want 00", req_ready); end
      tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rmid_busy: got %b want 0", busy); end
      tests++; if (udp_dst_port_out !== 16'h0) begin failed++; $display("FAIL rmid_port: got %0d want 0", udp_dst_port_out); end
      repeat (2) @(negedge eth_refclk);
      rst_n = 1'b1;
      repeat (2) @(negedge eth_refclk);
      clr_mon();
      req_data = {16'h7A01, 16'h7A00};
      req_port = {16'd99, 16'd7};
      req_last = 2'b11;
      req_valid = 2'b11;
      t = 0;
      while (!axiov && t < 50) begin
         @(negedge eth_refclk);
         t++;
      end
      req_valid = 2'b00;
      req_last = 2'b00;
      wait_idle();
      tests++; if (gnt_q[0] !== 0) begin failed++; $display("FAIL rmid_regrant: got %0d want 0", gnt_q[0]); end
      tests++; if (words_q.size() !== 1) begin failed++; $display("FAIL rmid_stale_words: got %0d words want 1", words_q.size()); end
      tests++; if (words_q[0] !== 16'h7A00) begin failed++; $display("FAIL rmid_word: got %h want 7a00", words_q[0]); end
      tests++; if (port_q[0] !== 16'd7) begin failed++; $display("FAIL rmid_port_after: got %0d want 7", port_q[0]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overlength();
      test_simultaneous();
      test_stall();
      test_gap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end
endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Shares the single `network_stack` transmit input between `NUM_REQ` payload sources, such as the sensor, button and debug packet generators.
- Grants one requester at a time and buffers its frame of up to `MAX_WORDS` words.
- Replays the frame to `axiiv`/`axiid` as one contiguous burst.
- Enforces an idle gap so the stack finishes the previous frame before the next burst starts.
- Runs in the `eth_refclk` domain.

## Interface

Parameters:
- `NUM_REQ`, 2: number of requesters (≥2).
- `DATA_SIZE`, 16: payload word width; matches `network_stack` `DATA_SIZE`.
- `MAX_WORDS`, 8: frame buffer depth, in words.
- `GAP_CYCLES`, 1024: idle cycles after each burst (≥1).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: `eth_refclk`; all state on its rising edge.
  - `rst_n` in 1: asynchronous active-low reset.
- Requester side:
  - `req_valid` in `NUM_REQ`: word offered by requester i.
  - `req_data` in `NUM_REQ*DATA_SIZE`: requester i word, carried in bits [i*DATA_SIZE +: DATA_SIZE].
  - `req_last` in `NUM_REQ`: offered word is the final word of its frame.
  - `req_port` in `NUM_REQ*16`: UDP destination port of requester i.
  - `req_ready` out `NUM_REQ`: word accepted when `req_valid[i] & req_ready[i]`.
- Stack side:
  - `axiov` out 1: drives `network_stack.axiiv`.
  - `axiod` out `DATA_SIZE`: drives `network_stack.axiid`.
  - `udp_dst_port_out` out 16: drives `network_stack.udp_dst_port_in`.
- Status:
  - `grant_id` out max(1,$clog2(NUM_REQ)): current or last granted requester.
  - `busy` out 1: high in any state other than IDLE.

## Operation

- States: IDLE, COLLECT, SEND, GAP.
- IDLE
  - If any `req_valid` bit is set, select a winner.
  - Round-robin: the first set bit scanning from `last_grant+1`, wrapping modulo `NUM_REQ`.
  - Latch `grant_id` and `udp_dst_port_out` from the winner's `req_port`, update `last_grant`, clear `count`, go to COLLECT.
- COLLECT
  - `req_ready[grant_id]=1` while `count<MAX_WORDS`; all other `req_ready` bits are 0.
  - On each handshake: `buf[count]<=req_data[grant_id]`, `count<=count+1`.
  - Go to SEND when the accepted word has `req_last=1`, or when it is word number `MAX_WORDS`.
  - On a forced split at `MAX_WORDS`, the requester's following words form a new frame and re-arbitrate.
  - If `req_valid` drops mid-frame, wait indefinitely; there is no timeout.
- SEND
  - `axiov=1` for exactly `count` consecutive cycles, with `axiod=buf[0..count-1]` in order.
  - Then go to GAP.
- GAP
  - `axiov=0` for `GAP_CYCLES` cycles, then go to IDLE.
- `udp_dst_port_out` holds stable from grant through the end of GAP.
- `req_last` is ignored unless `req_valid` is also high.
- `count` is $clog2(MAX_WORDS+1) bits wide and never wraps.

## Timing

- Reset values: `axiov=0`, `axiod=0`, `req_ready=0`, `udp_dst_port_out=0`, `grant_id=0`, `busy=0`, state IDLE, `last_grant=NUM_REQ-1` (so requester 0 wins first), `buf` contents don't-care.
- All outputs are driven from flops or from a decode of state/`count`. There is no combinational path from `req_*` inputs to `req_ready`.
- Latency:
  - `req_valid` seen in IDLE at cycle t → COLLECT and `req_ready` high at t+1.
  - Last word accepted at cycle c → first `axiov` at c+1, last `axiov` at c+n.
  - `busy` falls at c+n+GAP_CYCLES+1.
  - Minimum frame period is n+GAP_CYCLES+2 cycles.
- A requester asserting `req_valid` during SEND/GAP is not acknowledged until the next IDLE.
- A single-word frame (`req_last` on the first word) gives a 1-cycle `axiov` pulse.
- Reset asserted mid-operation: all outputs drop asynchronously and the partial frame is discarded. After reset releases, arbitration restarts from requester 0.

## Configuration

- Macro: `TX_ARB_FIXED_PRIORITY_EN`.
- Defined: fixed priority; the lowest-index requester with `req_valid` wins, and `last_grant` is unused.
- Undefined (default): round-robin as above.

## Test plan

- Reset then single request: requester 0 sends 0xABCD, 0x6969 (last) with port 42069 → `axiov` high 2 cycles carrying 0xABCD, 0x6969; `udp_dst_port_out=42069`; `busy` low after GAP.
- Simultaneous request: req 0 and 1 both valid and both hold continuously → grants alternate 0,1,0,1. With `TX_ARB_FIXED_PRIORITY_EN` defined, requester 0 wins every time.
- Overlength frame: requester 1 sends 10 words with `last` on word 10, `MAX_WORDS=8` → an 8-word burst, then after GAP a 2-word burst; `req_ready` is low during SEND/GAP.
- Stall mid-frame: requester 0 drops `req_valid` for 20 cycles after word 2 → stays in COLLECT, `axiov` stays 0; the burst starts 1 cycle after `last` is accepted.
- Reset mid-SEND: `rst_n` low on burst word 3 → `axiov`, `req_ready` and `busy` go to 0 immediately. A new request after release is granted to requester 0 and its burst contains no stale words.
- Gap check: back-to-back single-word frames from one requester → `axiov` rising edges exactly 1+GAP_CYCLES+2 cycles apart.
